// File: rtl/sipo_pkg.sv
// Shared constants and shift-direction type for the serial-in/parallel-out shift register.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

  typedef enum logic {
    SHIFT_DIR_RIGHT = 1'b0,
    SHIFT_DIR_LEFT  = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/sipo_fill_counter.sv
// Saturating count of shifts since reset; valid marks a fully populated shift chain.
module sipo_fill_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  output logic valid
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count != FULL) begin
      count <= count + CW'(1);
    end
  end

  assign valid = (count == FULL);

endmodule

// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register; shifts one bit per clock with no enable.
// Optional word-complete indicator enabled by defining SIPO_VALID_EN.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH      = SIPO_DEFAULT_WIDTH,
  parameter bit          SHIFT_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
`ifdef SIPO_VALID_EN
  output logic             valid,
`endif
  output logic [WIDTH-1:0] out
);

  localparam shift_dir_e DIR = shift_dir_e'(SHIFT_LEFT);

  if (WIDTH < 2) begin : g_width_check
    $error("sipo_shift_reg: WIDTH must be at least 2");
  end

  if (DIR == SHIFT_DIR_LEFT) begin : g_left
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out <= '0;
      end else begin
        out <= {out[WIDTH-2:0], in};
      end
    end
  end else begin : g_right
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out <= '0;
      end else begin
        out <= {in, out[WIDTH-1:1]};
      end
    end
  end

`ifdef SIPO_VALID_EN
  sipo_fill_counter #(
    .WIDTH (WIDTH)
  ) u_fill_counter (
    .clk   (clk),
    .rst   (rst),
    .valid (valid)
  );
`endif

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Scoreboard bench for sipo_shift_reg: 4-bit left, 4-bit right and 8-bit left instances
// driven in lockstep; valid is checked when SIPO_VALID_EN is defined.
module tb_sipo_shift_reg;

  logic       clk;
  logic       rst;
  logic       in_l, in_r, in_w;
  logic [3:0] out_l, out_r;
  logic [7:0] out_w;
  logic       valid_l, valid_r, valid_w;

  int unsigned checks;
  int unsigned errors;

  typedef struct {
    logic [3:0] el;
    logic [3:0] er;
    logic [7:0] ew;
    logic       v4;
    logic       v8;
  } exp_t;

  exp_t q[$];

  sipo_shift_reg #(.WIDTH(4), .SHIFT_LEFT(1'b1)) dut_l (
    .clk   (clk),
    .rst   (rst),
    .in    (in_l),
`ifdef SIPO_VALID_EN
    .valid (valid_l),
`endif
    .out   (out_l)
  );

  sipo_shift_reg #(.WIDTH(4), .SHIFT_LEFT(1'b0)) dut_r (
    .clk   (clk),
    .rst   (rst),
    .in    (in_r),
`ifdef SIPO_VALID_EN
    .valid (valid_r),
`endif
    .out   (out_r)
  );

  sipo_shift_reg #(.WIDTH(8), .SHIFT_LEFT(1'b1)) dut_w (
    .clk   (clk),
    .rst   (rst),
    .in    (in_w),
`ifdef SIPO_VALID_EN
    .valid (valid_w),
`endif
    .out   (out_w)
  );

`ifndef SIPO_VALID_EN
  assign valid_l = 1'b0;
  assign valid_r = 1'b0;
  assign valid_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each rising edge commits one shift; compare just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("out_l", 8'(out_l), 8'(e.el));
      check("out_r", 8'(out_r), 8'(e.er));
      check("out_w", out_w, e.ew);
`ifdef SIPO_VALID_EN
      check("valid_l", 8'(valid_l), 8'(e.v4));
      check("valid_r", 8'(valid_r), 8'(e.v4));
      check("valid_w", 8'(valid_w), 8'(e.v8));
`endif
    end
  end

  task automatic step(input logic il, input logic ir, input logic iw,
                      input logic [3:0] el, input logic [3:0] er, input logic [7:0] ew,
                      input logic v4, input logic v8);
    @(negedge clk);
    in_l = il;
    in_r = ir;
    in_w = iw;
    q.push_back(exp_t'{el, er, ew, v4, v8});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_l"}, 8'(out_l), 8'h00);
    check({name, "_r"}, 8'(out_r), 8'h00);
    check({name, "_w"}, out_w, 8'h00);
`ifdef SIPO_VALID_EN
    check({name, "_vl"}, 8'(valid_l), 8'h00);
    check({name, "_vw"}, 8'(valid_w), 8'h00);
`endif
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b0;
    in_l = 1'b1;
    in_r = 1'b1;
    in_w = 1'b1;

    // Held in reset with in=1 and clock running: everything stays zero.
    repeat (3) step(1, 1, 1, 4'h0, 4'h0, 8'h00, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // L: 1,1,0,1,1,0,0,0,0,1   R: 1,0,0,0,1,1,0,0,0,0   W: 0xA5 MSB-first then 0,0
    step(1, 1, 1, 4'b0001, 4'b1000, 8'h01, 0, 0);
    step(1, 0, 0, 4'b0011, 4'b0100, 8'h02, 0, 0);
    step(0, 0, 1, 4'b0110, 4'b0010, 8'h05, 0, 0);
    step(1, 0, 0, 4'b1101, 4'b0001, 8'h0A, 1, 0);
    step(1, 1, 0, 4'b1011, 4'b1000, 8'h14, 1, 0);
    step(0, 1, 1, 4'b0110, 4'b1100, 8'h29, 1, 0);
    step(0, 0, 0, 4'b1100, 4'b0110, 8'h52, 1, 0);
    step(0, 0, 1, 4'b1000, 4'b0011, 8'hA5, 1, 1);
    step(0, 0, 0, 4'b0000, 4'b0001, 8'h4A, 1, 1);
    step(1, 0, 0, 4'b0001, 4'b0000, 8'h94, 1, 1);

    // Asynchronous reset between edges after 10 shifts.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_after10");
    @(posedge clk);
    #2 rst = 1'b1;

    step(1, 1, 1, 4'b0001, 4'b1000, 8'h01, 0, 0);
    step(1, 0, 1, 4'b0011, 4'b0100, 8'h03, 0, 0);
    step(0, 0, 0, 4'b0110, 4'b0010, 8'h06, 0, 0);

    // Mid-word reset with out_l = 0110: cleared before the next edge, then restart from zero.
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("rst_midword");
    rst = 1'b1;
    step(1, 1, 1, 4'b0001, 4'b1000, 8'h01, 0, 0);
    step(0, 0, 0, 4'b0010, 4'b0100, 8'h02, 0, 0);

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
